// File: rtl/yannickreiss_diamond_route_ctrl_if.sv
// yannickreiss_diamond_route_ctrl_if: entry requests, occupancy and route command lines of the diamond
interface yannickreiss_diamond_route_ctrl_if;
  logic [3:0] req, req_cross, grant, sig;
  logic occ, sw_set, sw_pulse, done, timeout_err;
  modport master(output req, req_cross, occ, input grant, sig, sw_set, sw_pulse, done, timeout_err);
  modport slave(input req, req_cross, occ, output grant, sig, sw_set, sw_pulse, done, timeout_err);
endinterface

// File: rtl/yannickreiss_diamond_route_ctrl.sv
// yannickreiss_diamond_route_ctrl: round-robin diamond route sequencer with timed switch throw
module yannickreiss_diamond_route_ctrl #(
  parameter int THROW_CYCLES = 8,
  parameter int SETTLE_CYCLES = 4,
  parameter int ENTRY_TIMEOUT = 200,
  parameter int CLEAR_CYCLES = 3
) (
  input logic clk,
  input logic rst_n,
  yannickreiss_diamond_route_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, THROW, SETTLE, CLEAR, OCCUPIED, RELEASE} state_t;
  state_t state_q, state_d;
  logic [1:0] rr_q, rr_d, win_q, win_d, pick;
  logic found;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] grant_q, grant_d, sig_q, sig_d;
  logic sw_set_q, sw_set_d, sw_pulse_q, sw_pulse_d, done_q, done_d, terr_q, terr_d;
  // descending scan so the request closest to rr is the last one written
  always_comb begin
    pick = rr_q;
    found = 1'b0;
    for (int i = 3; i >= 0; i--)
      if (bus.req[rr_q + 2'(i)]) begin
        pick = rr_q + 2'(i);
        found = 1'b1;
      end
  end
  always_comb begin
    state_d = state_q;
    rr_d = rr_q;
    win_d = win_q;
    cnt_d = cnt_q;
    grant_d = grant_q;
    sig_d = 4'b0;
    sw_set_d = sw_set_q;
    sw_pulse_d = 1'b0;
    done_d = 1'b0;
    terr_d = 1'b0;
    case (state_q)
      IDLE:
        if (found && !bus.occ) begin
          win_d = pick;
          grant_d = 4'b1 << pick;
          if (bus.req_cross[pick] != sw_set_q) begin
            sw_set_d = ~sw_set_q;
            sw_pulse_d = 1'b1;
            state_d = THROW;
            cnt_d = 8'(THROW_CYCLES - 1);
          end else begin
            state_d = CLEAR;
            cnt_d = 8'(ENTRY_TIMEOUT);
          end
        end
      THROW:
        if (cnt_q == 8'd0) begin
          state_d = SETTLE;
          cnt_d = 8'(SETTLE_CYCLES - 1);
        end else begin
          sw_pulse_d = 1'b1;
          cnt_d = cnt_q - 8'd1;
        end
      SETTLE:
        if (cnt_q == 8'd0) begin
          state_d = CLEAR;
          cnt_d = 8'(ENTRY_TIMEOUT);
        end else cnt_d = cnt_q - 8'd1;
      // signal shows from the second CLEAR cycle; a withdrawn request outranks the timeout
      CLEAR:
        if (bus.occ) begin
          state_d = OCCUPIED;
          cnt_d = 8'(CLEAR_CYCLES - 1);
        end else if (!bus.req[win_q] || cnt_q == 8'd0) begin
          state_d = RELEASE;
          grant_d = 4'b0;
          done_d = !bus.req[win_q];
          terr_d = bus.req[win_q];
        end else begin
          sig_d = grant_q;
          cnt_d = cnt_q - 8'd1;
        end
      OCCUPIED:
        if (bus.occ) cnt_d = 8'(CLEAR_CYCLES - 1);
        else if (cnt_q == 8'd0) begin
          state_d = RELEASE;
          grant_d = 4'b0;
          done_d = 1'b1;
        end else cnt_d = cnt_q - 8'd1;
      RELEASE: begin
        state_d = IDLE;
        rr_d = win_q + 2'd1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      rr_q <= 2'd0;
      win_q <= 2'd0;
      cnt_q <= 8'd0;
      grant_q <= 4'b0;
      sig_q <= 4'b0;
      sw_set_q <= 1'b0;
      sw_pulse_q <= 1'b0;
      done_q <= 1'b0;
      terr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q <= rr_d;
      win_q <= win_d;
      cnt_q <= cnt_d;
      grant_q <= grant_d;
      sig_q <= sig_d;
      sw_set_q <= sw_set_d;
      sw_pulse_q <= sw_pulse_d;
      done_q <= done_d;
      terr_q <= terr_d;
    end
  assign bus.grant = grant_q;
  assign bus.sig = sig_q;
  assign bus.sw_set = sw_set_q;
  assign bus.sw_pulse = sw_pulse_q;
  assign bus.done = done_q;
  assign bus.timeout_err = terr_q;
endmodule
